// File: rtl/hpu_core_sequencer.sv
// Sequencer in front of the HD core array: item-memory generation, instruction FIFO, issue with
// store-credit throttling, drain on last. Optional perf counters under `ifdef PERF_CNT_EN.
module hpu_core_sequencer #(
    parameter int unsigned FIFO_AW    = 4,
    parameter int unsigned ST_CREDITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  item_num,
    input  logic        rand_v,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    input  logic        st_free,
    input  logic        core_last,
    output logic        run,
    output logic        gen,
    output logic        update_item,
    output logic [9:0]  item_a,
    output logic        get_v,
    output logic [15:0] get_d,
    output logic        exec,
    output logic        busy,
    output logic        done
`ifdef PERF_CNT_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] inst_cnt,
    output logic [31:0] stall_cnt
`endif
);

    typedef enum logic [2:0] {StIdle, StGen, StRun, StDrain, StDone} state_e;

    localparam int unsigned Depth    = 1 << FIFO_AW;
    localparam logic [3:0]  CredMax  = 4'(ST_CREDITS);
    localparam logic [15:0] InstLast = 16'h0400;

    state_e             state_q, state_d;
    logic [9:0]         item_num_q, item_num_d;
    logic [9:0]         item_a_q, item_a_d;
    logic [3:0]         credits_q, credits_d;
    logic               last_seen_q, last_seen_d;
    logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
    logic               get_v_q, get_v_d;
    logic [15:0]        get_d_q, get_d_d;
    logic               exec_q, exec_d;
    logic [15:0]        mem_q [Depth];

    logic        empty, full, head_store, issue, push, pop;
    logic [15:0] head;

    assign empty = wr_ptr_q == rd_ptr_q;
    assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                   (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign head  = mem_q[rd_ptr_q[FIFO_AW-1:0]];

    assign head_store = ~head[15] & (head[14:12] == 3'b000) & head[11];
    assign issue      = (state_q == StRun) & ~empty & ~last_seen_q &
                        (~head_store | (credits_q != 4'd0));
    assign pop        = issue;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign s_ready    = ((state_q == StGen) || (state_q == StRun)) & (~full | pop);
    assign push       = s_valid & s_ready;

    assign gen         = state_q == StGen;
    assign run         = state_q != StIdle;
    assign busy        = state_q != StIdle;
    assign done        = state_q == StDone;
    assign update_item = rand_v & gen;
    assign item_a      = item_a_q;
    assign get_v       = get_v_q;
    assign get_d       = get_d_q;
    assign exec        = exec_q;

    always_comb begin
        state_d     = state_q;
        item_num_d  = item_num_q;
        item_a_d    = item_a_q;
        credits_d   = credits_q;
        last_seen_d = last_seen_q;
        wr_ptr_d    = wr_ptr_q + {{FIFO_AW{1'b0}}, push};
        rd_ptr_d    = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
        get_v_d     = issue;
        get_d_d     = issue ? head : 16'h0000;
        exec_d      = get_v_q;

        if ((issue && head_store) && !st_free) begin
            credits_d = credits_q - 4'd1;
        end else if (!(issue && head_store) && st_free && (credits_q < CredMax)) begin
            credits_d = credits_q + 4'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StGen;
                    item_num_d = item_num;
                    item_a_d   = 10'd0;
                end
            end
            StGen: begin
                if (update_item) begin
                    if (item_a_q == item_num_q) begin
                        state_d  = StRun;
                        item_a_d = 10'd0;
                    end else begin
                        item_a_d = item_a_q + 10'd1;
                    end
                end
            end
            StRun: begin
                if (issue && (head == InstLast)) begin
                    last_seen_d = 1'b1;
                    state_d     = StDrain;
                end
            end
            StDrain: begin
                if (core_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d     = StIdle;
                wr_ptr_d    = '0;
                rd_ptr_d    = '0;
                last_seen_d = 1'b0;
                credits_d   = CredMax;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            item_num_q  <= 10'd0;
            item_a_q    <= 10'd0;
            credits_q   <= CredMax;
            last_seen_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            get_v_q     <= 1'b0;
            get_d_q     <= 16'h0000;
            exec_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            item_num_q  <= item_num_d;
            item_a_q    <= item_a_d;
            credits_q   <= credits_d;
            last_seen_q <= last_seen_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            get_v_q     <= get_v_d;
            get_d_q     <= get_d_d;
            exec_q      <= exec_d;
        end
    end

    // Storage needs no reset; pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[FIFO_AW-1:0]] <= s_data;
        end
    end

`ifdef PERF_CNT_EN
    logic [31:0] cyc_cnt_q, cyc_cnt_d;
    logic [31:0] inst_cnt_q, inst_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        cyc_cnt_d   = cyc_cnt_q;
        inst_cnt_d  = inst_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((state_q == StIdle) && start) begin
            cyc_cnt_d   = 32'd0;
            inst_cnt_d  = 32'd0;
            stall_cnt_d = 32'd0;
        end else begin
            if ((state_q == StRun) || (state_q == StDrain)) begin
                cyc_cnt_d = cyc_cnt_q + 32'd1;
            end
            if (get_v_q) begin
                inst_cnt_d = inst_cnt_q + 32'd1;
            end
            if ((state_q == StRun) && !empty && !issue) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_cnt_q   <= 32'd0;
            inst_cnt_q  <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            cyc_cnt_q   <= cyc_cnt_d;
            inst_cnt_q  <= inst_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cyc_cnt   = cyc_cnt_q;
    assign inst_cnt  = inst_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hpu_core_sequencer.sv
// Directed bench for hpu_core_sequencer (FIFO_AW=2, ST_CREDITS=2): vector table plus
// hand-written credit, back-pressure, last-word and async-reset sequences.
module tb_hpu_core_sequencer;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, rand_v, s_valid, st_free, core_last;
    logic [9:0]  item_num;
    logic [15:0] s_data;
    logic        s_ready, run, gen, update_item, get_v, exec, busy, done;
    logic [9:0]  item_a;
    logic [15:0] get_d;

    int checks = 0;
    int errors = 0;
    int accepted = 0;
    logic [15:0] issued_q [$];

    always #5 clk = ~clk;

    hpu_core_sequencer #(
        .FIFO_AW   (2),
        .ST_CREDITS(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .item_num   (item_num),
        .rand_v     (rand_v),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .st_free    (st_free),
        .core_last  (core_last),
        .run        (run),
        .gen        (gen),
        .update_item(update_item),
        .item_a     (item_a),
        .get_v      (get_v),
        .get_d      (get_d),
        .exec       (exec),
        .busy       (busy),
        .done       (done)
    );

    // Records issued words and accepted pushes on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (get_v) issued_q.push_back(get_d);
            if (s_valid && s_ready) accepted++;
        end
    end

    typedef struct packed {
        logic        start;
        logic [9:0]  item_num;
        logic        rand_v;
        logic        s_valid;
        logic [15:0] s_data;
        logic        core_last;
        logic        run;
        logic        gen;
        logic        upd;
        logic [9:0]  item_a;
        logic        s_ready;
        logic        get_v;
        logic [15:0] get_d;
        logic        exec;
        logic        busy;
        logic        done;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_run"}, 32'(run), 32'd0);
        chk({tag, "_gen"}, 32'(gen), 32'd0);
        chk({tag, "_upd"}, 32'(update_item), 32'd0);
        chk({tag, "_item_a"}, 32'(item_a), 32'd0);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
        chk({tag, "_get_v"}, 32'(get_v), 32'd0);
        chk({tag, "_get_d"}, 32'(get_d), 32'd0);
        chk({tag, "_exec"}, 32'(exec), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // Start a job with one item; returns at the first RUN cycle.
    task automatic begin_job();
        start = 1'b1; item_num = 10'd0;
        tick();
        start = 1'b0; rand_v = 1'b1;
        tick();
        rand_v = 1'b0;
        sample();
        chk("job_run_gen", {30'd0, run, gen}, 32'd2);
        tick();
    endtask

    task automatic push_word(input logic [15:0] w);
        s_valid = 1'b1; s_data = w;
        tick();
        s_valid = 1'b0; s_data = 16'h0000;
    endtask

    task automatic finish_job(input string tag);
        core_last = 1'b1;
        tick();
        core_last = 1'b0;
        sample();
        chk({tag, "_done"}, 32'(done), 32'd1);
        tick();
        sample();
        chk({tag, "_done_off"}, 32'(done), 32'd0);
        chk({tag, "_run_off"}, 32'(run), 32'd0);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        tick();
    endtask

    initial begin
        //             start item rand s_v  s_data     cl | run gen upd item_a rdy  gv   get_d      ex  busy done
        vecs[0]  = '{H, 10'd3, L, L, 16'h0000, L, L, L, L, 10'd0, L, L, 16'h0000, L, L, L};
        vecs[1]  = '{L, 10'd7, H, H, 16'h8005, L, H, H, H, 10'd0, H, L, 16'h0000, L, H, L};
        vecs[2]  = '{L, 10'd7, L, H, 16'h0200, L, H, H, L, 10'd1, H, L, 16'h0000, L, H, L};
        vecs[3]  = '{L, 10'd7, H, H, 16'h0400, L, H, H, H, 10'd1, H, L, 16'h0000, L, H, L};
        vecs[4]  = '{L, 10'd7, H, L, 16'h0000, L, H, H, H, 10'd2, H, L, 16'h0000, L, H, L};
        vecs[5]  = '{L, 10'd7, H, L, 16'h0000, L, H, H, H, 10'd3, H, L, 16'h0000, L, H, L};
        vecs[6]  = '{L, 10'd7, H, L, 16'h0000, L, H, L, L, 10'd0, H, L, 16'h0000, L, H, L};
        vecs[7]  = '{H, 10'd7, L, L, 16'h0000, L, H, L, L, 10'd0, H, H, 16'h8005, L, H, L};
        vecs[8]  = '{L, 10'd7, L, L, 16'h0000, L, H, L, L, 10'd0, H, H, 16'h0200, H, H, L};
        vecs[9]  = '{L, 10'd7, L, L, 16'h0000, L, H, L, L, 10'd0, L, H, 16'h0400, H, H, L};
        vecs[10] = '{L, 10'd7, L, L, 16'h0000, L, H, L, L, 10'd0, L, L, 16'h0000, H, H, L};
        vecs[11] = '{L, 10'd7, L, L, 16'h0000, L, H, L, L, 10'd0, L, L, 16'h0000, L, H, L};
        vecs[12] = '{L, 10'd7, L, L, 16'h0000, H, H, L, L, 10'd0, L, L, 16'h0000, L, H, L};
        vecs[13] = '{L, 10'd7, L, L, 16'h0000, L, H, L, L, 10'd0, L, L, 16'h0000, L, H, H};
        vecs[14] = '{L, 10'd7, L, L, 16'h0000, L, L, L, L, 10'd0, L, L, 16'h0000, L, L, L};

        rst = 1'b1; start = 1'b0; item_num = 10'd0; rand_v = 1'b0; s_valid = 1'b0;
        s_data = 16'h0000; st_free = 1'b0; core_last = 1'b0;
        sample();
        chk_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // Generation, issue timing, drain and done.
        for (int i = 0; i < NV; i++) begin
            start = vecs[i].start; item_num = vecs[i].item_num; rand_v = vecs[i].rand_v;
            s_valid = vecs[i].s_valid; s_data = vecs[i].s_data; core_last = vecs[i].core_last;
            sample();
            chk($sformatf("v%0d_run", i), 32'(run), 32'(vecs[i].run));
            chk($sformatf("v%0d_gen", i), 32'(gen), 32'(vecs[i].gen));
            chk($sformatf("v%0d_upd", i), 32'(update_item), 32'(vecs[i].upd));
            chk($sformatf("v%0d_item_a", i), 32'(item_a), 32'(vecs[i].item_a));
            chk($sformatf("v%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].s_ready));
            chk($sformatf("v%0d_get_v", i), 32'(get_v), 32'(vecs[i].get_v));
            if (vecs[i].get_v) chk($sformatf("v%0d_get_d", i), 32'(get_d), 32'(vecs[i].get_d));
            chk($sformatf("v%0d_exec", i), 32'(exec), 32'(vecs[i].exec));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].done));
            tick();
        end
        start = 1'b0; rand_v = 1'b0; s_valid = 1'b0; core_last = 1'b0;

        // Credits: only two stores go out until a slot is freed.
        begin_job();
        issued_q.delete();
        accepted = 0;
        for (int i = 0; i < 4; i++) push_word(16'h0800);
        repeat (6) tick();
        sample();
        chk("cred_accepted", 32'(accepted), 32'd4);
        chk("cred_issued2", 32'(issued_q.size()), 32'd2);
        tick();
        st_free = 1'b1;
        tick();
        st_free = 1'b0;
        sample();
        chk("cred_gap_get_v", 32'(get_v), 32'd0);
        tick();
        sample();
        chk("cred_third_get_v", 32'(get_v), 32'd1);
        chk("cred_third_get_d", 32'(get_d), 32'h0800);
        repeat (4) tick();
        sample();
        chk("cred_issued3", 32'(issued_q.size()), 32'd3);

        // Back-pressure: drain the last store, then fill the FIFO behind a blocked store.
        tick();
        st_free = 1'b1;
        tick();
        st_free = 1'b0;
        repeat (3) tick();
        accepted = 0;
        s_valid = 1'b1; s_data = 16'h0800;
        repeat (8) tick();
        sample();
        chk("bp_accepted4", 32'(accepted), 32'd4);
        chk("bp_ready_low", 32'(s_ready), 32'd0);
        chk("bp_issued4", 32'(issued_q.size()), 32'd4);
        tick();
        st_free = 1'b1;
        tick();
        st_free = 1'b0;
        sample();
        chk("bp_ready_reassert", 32'(s_ready), 32'd1);
        tick();
        sample();
        chk("bp_issue_get_v", 32'(get_v), 32'd1);
        chk("bp_issue_get_d", 32'(get_d), 32'h0800);
        chk("bp_accepted5", 32'(accepted), 32'd5);
        chk("bp_ready_full", 32'(s_ready), 32'd0);

        // Asynchronous reset mid-RUN with get_v high.
        #1 rst = 1'b1;
        #1;
        chk_all_zero("areset");
        s_valid = 1'b0; s_data = 16'h0000;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Words after last are never issued.
        begin_job();
        issued_q.delete();
        push_word(16'h0400);
        push_word(16'h8001);
        repeat (6) tick();
        sample();
        chk("last_issued1", 32'(issued_q.size()), 32'd1);
        chk("last_word", (issued_q.size() > 0) ? 32'(issued_q[0]) : 32'hdead_beef, 32'h0400);
        chk("last_drain_run", 32'(run), 32'd1);
        chk("last_drain_ready", 32'(s_ready), 32'd0);
        tick();
        finish_job("last");

        // A new job after DONE sees an empty FIFO.
        begin_job();
        issued_q.delete();
        push_word(16'h0200);
        push_word(16'h0400);
        repeat (6) tick();
        sample();
        chk("clr_issued2", 32'(issued_q.size()), 32'd2);
        chk("clr_first", (issued_q.size() > 0) ? 32'(issued_q[0]) : 32'hdead_beef, 32'h0200);
        chk("clr_second", (issued_q.size() > 1) ? 32'(issued_q[1]) : 32'hdead_beef, 32'h0400);
        tick();
        finish_job("clr");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
